// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: register width, RISC-V load/store funct3 codes and
// the access-size decode helpers used by the sequencer and its lane logic.
`ifndef LSU_CTRL_DEFINES
`define LSU_CTRL_DEFINES
`define REG_LEN 32
`define SB  3'b000
`define SH  3'b001
`define SW  3'b010
`define LB  3'b000
`define LH  3'b001
`define LW  3'b010
`define LBU 3'b100
`define LHU 3'b101
`endif

package lsu_ctrl_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e access_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) bad = !(f3 inside {`SB, `SH, `SW});
        else    bad = !(f3 inside {`LB, `LH, `LW, `LBU, `LHU});
        return bad;
    endfunction

    function automatic logic addr_misaligned(input lsu_size_e sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Natural alignment: drop the low address bits the access size cannot use.
    function automatic logic [1:0] align_low(input lsu_size_e sz, input logic [1:0] lo);
        logic [1:0] al;
        case (sz)
            SZ_HALF: al = {lo[1], 1'b0};
            SZ_WORD: al = 2'b00;
            default: al = lo;
        endcase
        return al;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and data-memory bus signals of the LSU sequencer.
// master: the sequencer itself; slave: the core plus memory around it.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic                lsu_valid;
    logic                lsu_we;
    logic [2:0]          lsu_funct3;
    logic [ADDR_W-1:0]   lsu_addr;
    logic [`REG_LEN-1:0] lsu_wdata;
    logic                lsu_busy;
    logic                lsu_done;
    logic                lsu_err;
    logic                lsu_misalign;
    logic [`REG_LEN-1:0] lsu_rdata;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [3:0]          mem_be;
    logic [`REG_LEN-1:0] mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [`REG_LEN-1:0] mem_rdata;

    modport master (
        input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output lsu_busy, lsu_done, lsu_err, lsu_misalign, lsu_rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  lsu_busy, lsu_done, lsu_err, lsu_misalign, lsu_rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_ctrl_load_extract.sv
// Load data extraction: picks the byte/half lane out of the read word and
// sign- or zero-extends it to the register width.
module load_extract
    import lsu_ctrl_pkg::*;
(
    input  lsu_size_e           size,
    input  logic                zext,
    input  logic [1:0]          addr_lo,
    input  logic [`REG_LEN-1:0] rdata,
    output logic [`REG_LEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: ;
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            SZ_BYTE: data = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/select_wr.sv
// Store-lane aligner: byte enables and lane-positioned write data for a
// byte/half/word access at the given low address bits.
module select_wr
    import lsu_ctrl_pkg::*;
(
    input  lsu_size_e           size,
    input  logic [1:0]          addr_lo,
    input  logic [`REG_LEN-1:0] wdata,
    output logic [3:0]          be,
    output logic [`REG_LEN-1:0] wdata_al
);

    always_comb begin
        be       = 4'b1111;
        wdata_al = wdata;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wdata_al = wdata << {addr_lo, 3'b000};
            end
            SZ_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-request load/store sequencer between execute stage and data bus.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [`REG_LEN-1:0] rdata_q;
    logic                rdata_ld;
    logic                latch;

    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [`REG_LEN-1:0] wdata_q;

    lsu_size_e           in_size, q_size;
    logic                in_illegal;
    logic [1:0]          in_lo;
    logic [3:0]          be_al;
    logic [`REG_LEN-1:0] wdata_al;
    logic [`REG_LEN-1:0] ext_data;
    logic                in_req;

    assign in_size    = access_size(bus.lsu_funct3);
    assign in_illegal = funct3_illegal(bus.lsu_we, bus.lsu_funct3);
    assign in_lo      = align_low(in_size, bus.lsu_addr[1:0]);
    assign q_size     = access_size(f3_q);

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic in_misal;
    assign in_misal = addr_misaligned(in_size, bus.lsu_addr[1:0]);
`endif

    select_wr u_select_wr (
        .size     (q_size),
        .addr_lo  (addr_q[1:0]),
        .wdata    (wdata_q),
        .be       (be_al),
        .wdata_al (wdata_al)
    );

    load_extract u_load_extract (
        .size    (q_size),
        .zext    (f3_q[2]),
        .addr_lo (addr_q[1:0]),
        .rdata   (bus.mem_rdata),
        .data    (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_ld = 1'b0;
        latch    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.lsu_valid) begin
                    latch = 1'b1;
                    cnt_d = '0;
                    err_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    mis_d = 1'b0;
`endif
                    if (in_illegal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (in_misal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        mis_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = S_REQ;
                    end
                end
            end
            // Grant wins over a coincident rvalid: the read data phase starts only in RESP.
            S_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = we_q ? S_DONE : S_RESP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.mem_rvalid) begin
                    state_d  = S_DONE;
                    rdata_ld = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (rdata_ld) rdata_q <= ext_data;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end
`endif

    // Request payload needs no reset: every bus output is gated by state.
    always_ff @(posedge clk) begin
        if (latch) begin
            we_q    <= bus.lsu_we;
            f3_q    <= bus.lsu_funct3;
            addr_q  <= {bus.lsu_addr[ADDR_W-1:2], in_lo};
            wdata_q <= bus.lsu_wdata;
        end
    end

    assign in_req = (state_q == S_REQ);

    assign bus.lsu_busy  = (state_q == S_IDLE) ? bus.lsu_valid : (state_q != S_DONE);
    assign bus.lsu_done  = (state_q == S_DONE);
    assign bus.lsu_err   = bus.lsu_done & err_q;
    assign bus.lsu_rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.lsu_misalign = bus.lsu_done & mis_q;
`else
    assign bus.lsu_misalign = 1'b0;
`endif

    assign bus.mem_req   = in_req;
    assign bus.mem_we    = in_req & we_q;
    assign bus.mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_be    = in_req ? be_al : 4'b0000;
    assign bus.mem_wdata = (in_req && we_q) ? wdata_al : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: transaction-level model plus per-cycle compare.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ctrl_if bus();

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic        chk_en = 1'b0;
    logic        e_busy, e_done, e_err, e_mis, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;

    int          cur_k;
    int          obs_done_k;
    logic        obs_req_seen, obs_err, obs_mis;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_illegal(input logic we, input logic [2:0] f3);
        if (we) return f3 > 3'd2;
        return (f3 == 3'd3) || (f3 >= 3'd6);
    endfunction

    function automatic logic [3:0] m_be(input int nb, input logic [31:0] eff);
        int mask;
        mask = ((1 << nb) - 1) << (eff % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input int nb, input logic [31:0] eff, input logic [31:0] w);
        if (nb == 1) return w << (8 * (eff % 4));
        if (nb == 2) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] eff, input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (eff % 4));
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b100:  return {24'h0, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return word;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     32'(bus.lsu_busy),     32'(e_busy));
            check("done",     32'(bus.lsu_done),     32'(e_done));
            check("err",      32'(bus.lsu_err),      32'(e_err));
            check("misalign", 32'(bus.lsu_misalign), 32'(e_mis));
            check("rdata",    bus.lsu_rdata,         e_rdata);
            check("mem_req",  32'(bus.mem_req),      32'(e_req));
            if (e_req) begin
                check("mem_we",   32'(bus.mem_we), 32'(e_we));
                check("mem_addr", bus.mem_addr,    e_addr);
                check("mem_be",   32'(bus.mem_be), 32'(e_be));
                if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
            end
            if (bus.mem_req) begin
                obs_req_seen = 1'b1;
                obs_addr     = bus.mem_addr;
                obs_be       = bus.mem_be;
                obs_wdata    = bus.mem_wdata;
            end
            if (bus.lsu_done) begin
                obs_done_k = cur_k;
                obs_err    = bus.lsu_err;
                obs_mis    = bus.lsu_misalign;
            end
        end
    end

    // gdly: REQ cycles before gnt; rdly: RESP cycles before rvalid (>=TIMEOUT means never).
    // noise adds gnt/rvalid pulses in phases where they must be ignored.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword,
                           input int gdly, input int rdly, input logic noise);
        int          nb, req_end, d;
        logic        ill, mis, trap, terr, ok_gnt, ok_rv;
        logic [31:0] eff, new_rdata;
        nb   = 1 << f3[1:0];
        ill  = m_illegal(we, f3);
        mis  = !ill && ((addr % nb) != 0);
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        eff  = addr - (addr % nb);
        if (ill || trap) begin
            d = 1; req_end = 0; terr = 1'b1;
        end else if (gdly >= TIMEOUT) begin
            req_end = TIMEOUT; d = TIMEOUT + 1; terr = 1'b1;
        end else begin
            req_end = 1 + gdly;
            if (we) begin
                d = 2 + gdly; terr = 1'b0;
            end else if (rdly >= TIMEOUT) begin
                d = 2 + gdly + TIMEOUT; terr = 1'b1;
            end else begin
                d = 3 + gdly + rdly; terr = 1'b0;
            end
        end
        new_rdata    = (!we && !terr) ? m_load(f3, eff, rword) : e_rdata;
        ok_gnt       = !ill && !trap && (gdly < TIMEOUT);
        ok_rv        = ok_gnt && !we && (rdly < TIMEOUT);
        obs_req_seen = 1'b0;
        obs_done_k   = -1;
        obs_err      = 1'b0;
        obs_mis      = 1'b0;

        bus.lsu_we     = we;
        bus.lsu_funct3 = f3;
        bus.lsu_addr   = addr;
        bus.lsu_wdata  = wdata;
        bus.mem_rdata  = rword;
        for (int k = 0; k <= d + 1; k++) begin
            cur_k         = k;
            bus.lsu_valid = (k <= d);
            bus.mem_gnt   = (ok_gnt && k == 1 + gdly) ||
                            (noise && (k == 0 || k == d || (!we && k >= 2 + gdly && k < d)));
            bus.mem_rvalid = (ok_rv && k == 2 + gdly + rdly) ||
                             (noise && k >= 1 && k <= req_end);
            e_busy  = (k < d);
            e_done  = (k == d);
            e_err   = (k == d) && terr;
            e_mis   = (k == d) && trap;
            e_req   = (k >= 1) && (k <= req_end);
            e_we    = we;
            e_addr  = eff & 32'hFFFF_FFFC;
            e_be    = m_be(nb, eff);
            e_wdata = m_wdata(nb, eff, wdata);
            if (k >= d) e_rdata = new_rdata;
            @(posedge clk);
            #1;
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.lsu_valid  = 1'b0;
        bus.lsu_we     = 1'b0;
        bus.lsu_funct3 = 3'b000;
        bus.lsu_addr   = '0;
        bus.lsu_wdata  = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        e_rdata        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus.lsu_busy), 32'h0);
        check("rst_done",  32'(bus.lsu_done), 32'h0);
        check("rst_err",   32'(bus.lsu_err),  32'h0);
        check("rst_mis",   32'(bus.lsu_misalign), 32'h0);
        check("rst_rdata", bus.lsu_rdata,     32'h0);
        check("rst_req",   32'(bus.mem_req),  32'h0);
        check("rst_addr",  bus.mem_addr,      32'h0);
        check("rst_be",    32'(bus.mem_be),   32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        run_txn(1'b1, 3'b000, 32'h103, 32'h12345678, 32'h0, 0, 0, 1'b0);
        check("sb_be",     32'(obs_be),     32'h8);
        check("sb_wdata",  obs_wdata,       32'h78000000);
        check("sb_addr",   obs_addr,        32'h100);
        check("sb_done_k", 32'(obs_done_k), 32'd2);

        run_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h00F00000, 0, 0, 1'b0);
        check("lb_rdata",  bus.lsu_rdata,   32'hFFFFFFF0);
        check("lb_done_k", 32'(obs_done_k), 32'd3);
        run_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h00F00000, 0, 0, 1'b0);
        check("lbu_rdata", bus.lsu_rdata, 32'h000000F0);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001ABCD, 0, 0, 1'b0);
        check("lh_rdata",  bus.lsu_rdata, 32'hFFFF8001);
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001ABCD, 0, 1, 1'b0);
        check("lhu_rdata", bus.lsu_rdata, 32'h00008001);
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h8001ABCD, 2, 1, 1'b1);
        check("lw_rdata",  bus.lsu_rdata, 32'h8001ABCD);

        run_txn(1'b1, 3'b001, 32'h102, 32'hA5A5BEEF, 32'h0, 5, 0, 1'b0);
        check("sh_be",     32'(obs_be),     32'hC);
        check("sh_wdata",  obs_wdata,       32'hBEEFBEEF);
        check("sh_done_k", 32'(obs_done_k), 32'd7);

        run_txn(1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 32'h0, 0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        check("sw_mis_req", 32'(obs_req_seen), 32'h0);
        check("sw_mis_err", 32'(obs_err),      32'h1);
        check("sw_mis_mis", 32'(obs_mis),      32'h1);
`else
        check("sw_mis_addr", obs_addr,     32'h100);
        check("sw_mis_be",   32'(obs_be),  32'hF);
        check("sw_mis_err",  32'(obs_err), 32'h0);
`endif

        run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h55555555, TIMEOUT + 4, 0, 1'b0);
        check("to_req_err",   32'(obs_err),      32'h1);
        check("to_req_k",     32'(obs_done_k),   32'(TIMEOUT + 1));
        check("to_req_rdata", bus.lsu_rdata,     32'h8001ABCD);
        run_txn(1'b0, 3'b000, 32'h301, 32'h0, 32'h55555555, 1, TIMEOUT + 4, 1'b1);
        check("to_rsp_err",   32'(obs_err),      32'h1);
        check("to_rsp_rdata", bus.lsu_rdata,     32'h8001ABCD);

        run_txn(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1);
        check("ill_ld_req", 32'(obs_req_seen), 32'h0);
        check("ill_ld_err", 32'(obs_err),      32'h1);
        run_txn(1'b1, 3'b011, 32'h100, 32'h1, 32'h0, 0, 0, 1'b0);
        check("ill_st_req", 32'(obs_req_seen), 32'h0);
        check("ill_st_err", 32'(obs_err),      32'h1);

        run_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h1234F00D, 0, 2, 1'b1);
`ifndef MISALIGN_TRAP_EN
        check("lh_fix_rdata", bus.lsu_rdata, 32'hFFFFF00D);
`endif
        run_txn(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 2, 0, 1'b1);
        check("sb1_be",    32'(obs_be), 32'h2);
        check("sb1_wdata", obs_wdata,   32'h0000A500);

        // Asynchronous reset in REQ, then in RESP, then stray bus responses.
        chk_en         = 1'b0;
        bus.lsu_valid  = 1'b1;
        bus.lsu_we     = 1'b0;
        bus.lsu_funct3 = 3'b010;
        bus.lsu_addr   = 32'h200;
        @(posedge clk);
        #1;
        check("rreq_before", 32'(bus.mem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rreq_drop", 32'(bus.mem_req),  32'h0);
        check("rreq_done", 32'(bus.lsu_done), 32'h0);
        bus.lsu_valid = 1'b0;
        #1;
        check("rreq_busy", 32'(bus.lsu_busy), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        bus.lsu_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        check("rrsp_busy", 32'(bus.lsu_busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rrsp_req",   32'(bus.mem_req),  32'h0);
        check("rrsp_done",  32'(bus.lsu_done), 32'h0);
        check("rrsp_rdata", bus.lsu_rdata,     32'h0);
        bus.lsu_valid = 1'b0;
        #2 rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_gnt    = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("stray_done",  32'(bus.lsu_done), 32'h0);
            check("stray_req",   32'(bus.mem_req),  32'h0);
            check("stray_rdata", bus.lsu_rdata,     32'h0);
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
